regfile_write_queue: RTL and testbench

- Writer-side front end for the 64-bit, 32-entry register file (x0 hardwired to zero; write on posedge clk when RegWrite=1; combinational reads).
- Accepts write-back results from upstream producers over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into the register file at one write per cycle.
- Forwards pending (not yet committed) values to the read ports, so consumers always see the newest architectural value.

---
 rtl/regfile_write_queue.sv | 86 ++++++++
 tb/tb_regfile_write_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Write-back queue in front of the 32 x XLEN register file: buffers producer results,
// drains one write per cycle and forwards uncommitted values to both read ports.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_rd,
    input  logic [XLEN-1:0]            in_data,
    output logic                       RegWrite,
    output logic [4:0]                 rd,
    output logic [XLEN-1:0]            writeData,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [XLEN-1:0]            rf_readData1,
    input  logic [XLEN-1:0]            rf_readData2,
    output logic [XLEN-1:0]            readData1,
    output logic [XLEN-1:0]            readData2,
    output logic [$clog2(DEPTH):0]     pending_count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rdMem   [DEPTH];
    logic [XLEN-1:0] dataMem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    // Writes to x0 complete the handshake but are never stored.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready && (in_rd != '0);
    assign pop      = (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rdMem[tail]   <= in_rd;
            dataMem[tail] <= in_data;
        end
    end

    assign RegWrite      = pop;
    assign empty         = !pop;
    assign pending_count = count;
    assign rd            = pop ? rdMem[head]   : '0;
    assign writeData     = pop ? dataMem[head] : '0;

    // Walk entries oldest to youngest so the last match is the newest value.
    function automatic logic [XLEN-1:0] forwardValue(input logic [4:0] rs,
                                                     input logic [XLEN-1:0] rfData);
        logic [XLEN-1:0] result;
        logic [PW-1:0]   idx;
        result = rfData;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (rdMem[idx] == rs)) result = dataMem[idx];
        end
        if (rs == '0) result = '0;
        return result;
    endfunction

    always_comb begin
        readData1 = forwardValue(rs1, rf_readData1);
        readData2 = forwardValue(rs2, rf_readData2);
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue with an attached register-file array
// and a reference model of the architectural register state.
module tb_regfile_write_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;
    logic            RegWrite;
    logic [4:0]      rd;
    logic [XLEN-1:0] writeData;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rf_readData1;
    logic [XLEN-1:0] rf_readData2;
    logic [XLEN-1:0] readData1;
    logic [XLEN-1:0] readData2;
    logic [CW-1:0]   pending_count;
    logic            empty;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entryT;

    entryT           sbQ[$];
    logic [XLEN-1:0] rf    [32] = '{default: '0};
    logic [XLEN-1:0] expRf [32] = '{default: '0};
    int              checks = 0;
    int              errors = 0;

    regfile_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .RegWrite(RegWrite), .rd(rd), .writeData(writeData),
        .rs1(rs1), .rs2(rs2),
        .rf_readData1(rf_readData1), .rf_readData2(rf_readData2),
        .readData1(readData1), .readData2(readData2),
        .pending_count(pending_count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT's write port; x0 reads zero.
    always @(posedge clk) begin
        if (RegWrite && rd != 5'd0) rf[rd] <= writeData;
    end
    assign rf_readData1 = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rf_readData2 = (rs2 == 5'd0) ? '0 : rf[rs2];

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] fwdModel(input logic [4:0] rs);
        logic [XLEN-1:0] r;
        if (rs == 5'd0) return '0;
        r = expRf[rs];
        foreach (sbQ[i]) if (sbQ[i].rd == rs) r = sbQ[i].data;
        return r;
    endfunction

    // Called at a negedge with inputs set; checks, then advances one full cycle.
    task automatic step();
        logic  accept;
        entryT e;
        #1;
        check("in_ready", in_ready, sbQ.size() < DEPTH);
        check("pending_count", pending_count, sbQ.size());
        check("empty", empty, sbQ.size() == 0);
        check("RegWrite", RegWrite, sbQ.size() != 0);
        if (sbQ.size() != 0) begin
            check("rd", rd, sbQ[0].rd);
            check("writeData", writeData, sbQ[0].data);
        end else begin
            check("rd_idle", rd, 0);
            check("writeData_idle", writeData, 0);
        end
        check("readData1", readData1, fwdModel(rs1));
        check("readData2", readData2, fwdModel(rs2));
        accept = in_valid && (sbQ.size() < DEPTH) && (in_rd != 5'd0);
        e.rd   = in_rd;
        e.data = in_data;
        @(posedge clk);
        if (sbQ.size() != 0) begin
            entryT h;
            h = sbQ.pop_front();
            expRf[h.rd] = h.data;
        end
        if (accept) sbQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [XLEN-1:0] d);
        in_valid = v;
        in_rd    = r;
        in_data  = d;
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; rs1 = '0; rs2 = '0;
        #1;
        check("reset_RegWrite", RegWrite, 0);
        check("reset_empty", empty, 1);
        check("reset_in_ready", in_ready, 1);
        check("reset_count", pending_count, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Single write to x5 and its commit.
        drive(1'b1, 5'd5, 64'd10);
        in_valid = 1'b0;
        #1;
        check("lat_RegWrite", RegWrite, 1);
        check("lat_rd", rd, 5);
        check("lat_writeData", writeData, 10);
        check("lat_count", pending_count, 1);
        step();
        check("commit_empty", empty, 1);
        check("rf_x5", rf[5], 64'd10);

        // x0 write is accepted but dropped; rs1=0 reads zero.
        rs1 = 5'd0;
        drive(1'b1, 5'd0, 64'd99);
        in_valid = 1'b0;
        #1;
        check("x0_count", pending_count, 0);
        check("x0_RegWrite", RegWrite, 0);
        check("x0_readData1", readData1, 0);
        step();

        // rs2 forwarding of x5.
        rs2 = 5'd5;
        drive(1'b0, 5'd0, 64'd0);
        check("rs2_from_rf", readData2, 64'd10);
        drive(1'b1, 5'd5, 64'd42);
        in_valid = 1'b0;
        #1;
        check("rs2_forward", readData2, 64'd42);
        step();
        step();
        check("rs2_after_commit", readData2, 64'd42);

        // Back-to-back writes to x3; newest value must win.
        rs1 = 5'd3;
        drive(1'b1, 5'd3, 64'd25);
        drive(1'b1, 5'd3, 64'd77);
        in_valid = 1'b0;
        #1;
        check("x3_forward_newest", readData1, 64'd77);
        step();
        step();
        check("rf_x3", rf[3], 64'd77);

        // Steady stream: in_ready must stay high.
        for (int i = 0; i < 5; i++) drive(1'b1, 5'(8 + i), 64'(1000 + i));
        drive(1'b0, 5'd0, 64'd0);
        drive(1'b0, 5'd0, 64'd0);

        // Random traffic with overlapping destinations.
        for (int i = 0; i < 60; i++) begin
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
        end
        drive(1'b0, 5'd0, 64'd0);
        drive(1'b0, 5'd0, 64'd0);

        // Asynchronous reset while a write is pending.
        drive(1'b1, 5'd20, 64'hA1);
        drive(1'b1, 5'd21, 64'hA2);
        drive(1'b1, 5'd22, 64'hA3);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("rst_RegWrite", RegWrite, 0);
        check("rst_count", pending_count, 0);
        check("rst_empty", empty, 1);
        sbQ.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b0, 5'd0, 64'd0);
        check("rf_x22_untouched", rf[22], 64'd0);

        for (int i = 0; i < 32; i++) check("rf_final", rf[i], expRf[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
